id_scoreboard: RTL and testbench

Register scoreboard and issue controller for the decode stage. It tracks general-purpose registers whose values are still pending from in-flight long-latency producers: all loads, LL and SC. It holds the decoded instruction in ID until its read and write registers are free. Decode feeds the register addresses and write enable it produced; the memory stage returns completions.

---
 rtl/id_scoreboard.sv | 115 +++++++++++
 tb/tb_id_scoreboard.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/id_scoreboard.sv
// Decode-stage register scoreboard: counts in-flight long-latency writes per GPR
// and holds the instruction in ID until its sources and destination are free.
module id_scoreboard #(
    parameter int MAX_PER_REG     = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_raddr1,
    input  logic [4:0]  id_raddr2,
    input  logic [4:0]  id_waddr,
    input  logic        id_we,
    input  logic        id_long,
    output logic        id_ready,
    input  logic        wb_valid,
    input  logic [4:0]  wb_waddr,
    input  logic        flush,
    output logic [31:0] busy,
    output logic [31:0] stall_cycles,
    output logic        sb_err
);
    localparam int CW = $clog2(MAX_PER_REG + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]   busy_q, busy_d;
    logic [31:0]   sat;
    logic [OW-1:0] total_q, total_d;
    logic [31:0]   stall_q, stall_d;
    logic          err_q, err_d;
    logic          raw1, raw2, waw_sat, cap_full;
    logic          long_wr, alloc, retire, wb_orphan;

    // busy_q mirrors (cnt != 0) exactly, so it doubles as the pending flag for hazards.
    assign raw1     = busy_q[id_raddr1];
    assign raw2     = busy_q[id_raddr2];
    assign long_wr  = id_we && id_long && (id_waddr != 5'd0);
    assign waw_sat  = long_wr && sat[id_waddr];
    assign cap_full = long_wr && (total_q == OW'(MAX_OUTSTANDING));
    assign id_ready = !(raw1 || raw2 || waw_sat || cap_full);

    assign alloc     = id_valid && id_ready && long_wr;
    assign retire    = wb_valid && (wb_waddr != 5'd0) && busy_q[wb_waddr];
    assign wb_orphan = wb_valid && (wb_waddr != 5'd0) && !busy_q[wb_waddr];

    assign busy_d[0] = 1'b0;
    assign sat[0]    = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_reg
            logic [CW-1:0] cnt_q, cnt_d;
            logic          inc, dec;

            assign inc = alloc  && (id_waddr == 5'(gi));
            assign dec = retire && (wb_waddr == 5'(gi));

            // A simultaneous alloc and retire on the same register cancel out.
            always_comb begin
                cnt_d = cnt_q;
                if (flush)
                    cnt_d = '0;
                else if (inc && !dec)
                    cnt_d = cnt_q + 1'b1;
                else if (dec && !inc)
                    cnt_d = cnt_q - 1'b1;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    cnt_q <= '0;
                else
                    cnt_q <= cnt_d;
            end

            assign busy_d[gi] = (cnt_d != '0);
            assign sat[gi]    = (cnt_q == CW'(MAX_PER_REG));
        end
    endgenerate

    always_comb begin
        total_d = total_q;
        if (flush)
            total_d = '0;
        else if (alloc && !retire)
            total_d = total_q + 1'b1;
        else if (retire && !alloc)
            total_d = total_q - 1'b1;

        stall_d = stall_q;
        if (id_valid && !id_ready && (stall_q != 32'hFFFF_FFFF))
            stall_d = stall_q + 32'd1;

        // Completions that arrive during a flush belong to discarded producers.
        err_d = err_q || (wb_orphan && !flush);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            total_q <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            total_q <= total_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign busy         = busy_q;
    assign stall_cycles = stall_q;
    assign sb_err       = err_q;
endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: directed scenarios plus randomized traffic
// compared against a per-register pending-count model.
module tb_id_scoreboard;
    localparam int MAXPR = 3;
    localparam int MAXO  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_raddr1 = '0, id_raddr2 = '0, id_waddr = '0;
    logic        id_we = 1'b0, id_long = 1'b0;
    logic        id_ready;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_waddr = '0;
    logic        flush = 1'b0;
    logic [31:0] busy, stall_cycles;
    logic        sb_err;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    int          m_cnt [32];
    int          m_total;
    logic [31:0] m_stall;
    bit          m_err;

    id_scoreboard #(.MAX_PER_REG(MAXPR), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_raddr1(id_raddr1), .id_raddr2(id_raddr2), .id_waddr(id_waddr),
        .id_we(id_we), .id_long(id_long), .id_ready(id_ready),
        .wb_valid(wb_valid), .wb_waddr(wb_waddr), .flush(flush),
        .busy(busy), .stall_cycles(stall_cycles), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive(input bit v, input int r1, input int r2, input int wa,
                         input bit we, input bit lg, input bit wbv, input int wba,
                         input bit fl);
        id_valid  = v;
        id_raddr1 = 5'(r1);
        id_raddr2 = 5'(r2);
        id_waddr  = 5'(wa);
        id_we     = we;
        id_long   = lg;
        wb_valid  = wbv;
        wb_waddr  = 5'(wba);
        flush     = fl;
    endtask

    function automatic bit m_ready();
        bit hz = 0;
        if (id_raddr1 != 0 && m_cnt[id_raddr1] != 0) hz = 1;
        if (id_raddr2 != 0 && m_cnt[id_raddr2] != 0) hz = 1;
        if (id_we && id_long && id_waddr != 0 && m_cnt[id_waddr] == MAXPR) hz = 1;
        if (id_we && id_long && id_waddr != 0 && m_total == MAXO) hz = 1;
        return !hz;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b = '0;
        for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] != 0);
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_total = 0;
        m_stall = '0;
        m_err   = 0;
    endtask

    // One clock: ready checked mid-cycle, registered state checked just after the edge.
    task automatic step();
        bit rdy;
        int old [32];
        @(negedge clk);
        rdy = m_ready();
        check("ready", {31'b0, id_ready}, {31'b0, rdy});
        old = m_cnt;
        if (id_valid && !rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (flush) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            m_total = 0;
        end else begin
            if (id_valid && rdy && id_we && id_long && id_waddr != 0) begin
                m_cnt[id_waddr]++;
                m_total++;
            end
            if (wb_valid && wb_waddr != 0) begin
                if (old[wb_waddr] != 0) begin
                    m_cnt[wb_waddr]--;
                    m_total--;
                end else begin
                    m_err = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        check("busy", busy, m_busy());
        check("stall", stall_cycles, m_stall);
        check("sb_err", {31'b0, sb_err}, {31'b0, m_err});
        cyc++;
        $display("cyc %0d v=%0b r1=%0d r2=%0d wa=%0d we=%0b lg=%0b rdy=%0b wb=%0b/%0d fl=%0b busy=%h stall=%0d err=%0b",
                 cyc, id_valid, id_raddr1, id_raddr2, id_waddr, id_we, id_long, rdy,
                 wb_valid, wb_waddr, flush, busy, stall_cycles, sb_err);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        drive(1, $urandom_range(1, 31), $urandom_range(1, 31), $urandom_range(1, 31), 1, 1, 0, 0, 0);
        #2;
        check("rst_busy", busy, 32'd0);
        check("rst_stall", stall_cycles, 32'd0);
        check("rst_err", {31'b0, sb_err}, 32'd0);
        check("rst_ready", {31'b0, id_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int q [$];
        model_reset();
        #3;
        do_reset();

        // No history: reading r5 is ready.
        drive(1, 5, 0, 0, 0, 0, 0, 0, 0); step();

        // LW r8, ADDU r8 stalls until the cycle after r8's writeback.
        drive(1, 1, 2, 8, 1, 1, 0, 0, 0); step();
        check("lw8_busy", busy[8], 1);
        drive(1, 8, 9, 10, 1, 0, 0, 0, 0); step(); step(); step();
        drive(1, 8, 9, 10, 1, 0, 1, 8, 0); step();
        check("wb8_busy", busy[8], 0);
        drive(1, 8, 9, 10, 1, 0, 0, 0, 0); step();

        // Load to r0 never allocates; reading r0 never stalls.
        drive(1, 0, 0, 0, 1, 1, 0, 0, 0); step();
        check("r0_busy", busy, 32'd0);
        drive(1, 0, 0, 3, 1, 0, 0, 0, 0); step();

        // Capacity: four loads fill the scoreboard, the fifth waits for any retire.
        for (int k = 1; k <= 4; k++) begin
            drive(1, 0, 0, k, 1, 1, 0, 0, 0); step();
        end
        drive(1, 0, 0, 9, 1, 1, 0, 0, 0); step();
        drive(1, 10, 0, 11, 1, 0, 0, 0, 0); step();
        drive(1, 0, 0, 9, 1, 1, 1, 2, 0); step();
        drive(1, 0, 0, 9, 1, 1, 0, 0, 0); step();
        check("cap_busy9", busy[9], 1);

        // Same-register alloc+retire, then WAW saturation on r7.
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0); step();
        drive(0, 0, 0, 0, 0, 0, 1, 3, 0); step();
        drive(1, 0, 0, 6, 1, 1, 0, 0, 0); step();
        drive(1, 0, 0, 6, 1, 1, 1, 6, 0); step();
        check("same_busy6", busy[6], 1);
        drive(0, 0, 0, 0, 0, 0, 1, 6, 0); step();
        drive(0, 0, 0, 0, 0, 0, 1, 4, 0); step();
        drive(0, 0, 0, 0, 0, 0, 1, 9, 0); step();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 7, 1, 1, 0, 0, 0); step();
        end
        drive(1, 0, 0, 7, 1, 1, 0, 0, 0); step(); step();

        // Flush with an orphan completion: counters clear, no error.
        drive(1, 0, 0, 7, 1, 1, 1, 12, 1); step();
        check("flush_busy", busy, 32'd0);
        check("flush_err", {31'b0, sb_err}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 1, 3, 0); step();
        check("orphan_err", {31'b0, sb_err}, 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step(); step();

        // Reset mid-flight, then the stale completion raises sb_err.
        do_reset();
        drive(1, 0, 0, 5, 1, 1, 0, 0, 0); step();
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 5, 0); step();
        check("stale_err", {31'b0, sb_err}, 32'd1);

        // Randomized traffic, completions mostly aimed at pending registers.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            q.delete();
            for (int i = 1; i < 32; i++) if (m_cnt[i] != 0) q.push_back(i);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1), 0, 0,
                  $urandom_range(0, 40) == 0);
            if ($urandom_range(0, 9) < 4) begin
                wb_valid = 1'b1;
                if (q.size() != 0 && $urandom_range(0, 19) != 0)
                    wb_waddr = 5'(q[$urandom_range(0, q.size() - 1)]);
                else
                    wb_waddr = 5'($urandom_range(0, 31));
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
